fetch_unit: RTL and testbench

//  RV64I instruction fetch stage; sits directly upstream of the F/D pipeline register.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV64I fetch stage: owns the fetch PC, issues in-order imem requests, tags returned words
// with their PC and presents one {pc,instr} per cycle to decode; redirects flush and drop stale words.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        regD_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        fetch_o_valid,
  output logic [63:0] fetch_o_pc,
  output logic [31:0] fetch_o_instr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [63:0] fifo_pc_mem    [DEPTH];
  logic [31:0] fifo_instr_mem [DEPTH];
  logic [63:0] tag_mem        [DEPTH];

  logic          allowed, req_fire, resp_ok, push, pop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] resp_dec;
  logic [1:0]    unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  // Words already pushed and words still owed (minus those to be dropped) share the FIFO credit.
  always_comb begin
    credit_used = {1'b0, inflight_q - drop_cnt_q} + {1'b0, count_q};
    allowed     = (credit_used < {1'b0, DEPTH_C}) && (inflight_q < DEPTH_C);
  end

  always_comb begin
    imem_req_valid = allowed & ~redirect_valid & ~rst;
    imem_req_addr  = fetch_pc_q;
    fetch_o_valid  = (count_q != '0) & ~rst;
    fetch_o_pc     = fetch_o_valid ? fifo_pc_mem[rd_ptr_q] : '0;
    fetch_o_instr  = fetch_o_valid ? fifo_instr_mem[rd_ptr_q] : '0;
  end

  always_comb begin
    req_fire = imem_req_valid & imem_req_ready;
    resp_ok  = imem_resp_valid & (inflight_q != '0) & ~rst;
    resp_dec = CW'(resp_ok);
    push     = resp_ok & ~redirect_valid & (drop_cnt_q == '0);
    pop      = fetch_o_valid & ~regD_stall & ~redirect_valid;

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 64'd4;
    end

    inflight_d = inflight_q + CW'(req_fire) - resp_dec;
    tag_wr_d   = tag_wr_q + PW'(req_fire);
    // Tags pop on every counted response, dropped or not, to stay aligned with memory order.
    tag_rd_d   = tag_rd_q + PW'(resp_ok);

    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      drop_cnt_d = inflight_q - resp_dec;
    end else if (resp_ok && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      fifo_pc_mem[wr_ptr_q]    <= tag_mem[tag_rd_q];
      fifo_instr_mem[wr_ptr_q] <= imem_resp_data;
    end
  end

  // A response with nothing outstanding means the memory side broke request ordering.
  resp_needs_inflight: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory model with variable latency feeds the DUT
// and a scoreboard of expected {pc,instr} checks every word handed to decode.
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int unsigned DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        regD_stall = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        fetch_o_valid;
  logic [63:0] fetch_o_pc;
  logic [31:0] fetch_o_instr;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .regD_stall     (regD_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .fetch_o_valid  (fetch_o_valid),
    .fetch_o_pc     (fetch_o_pc),
    .fetch_o_instr  (fetch_o_instr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int pop_cnt  = 0;

  bit rand_ready = 1'b0;
  int lat_min    = 1;
  int lat_max    = 1;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];
  int    last_due = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_next = RESET_PC;
  logic [63:0] req_exp  = RESET_PC;
  bit          req_hold = 1'b0;
  logic [63:0] held_addr = '0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    logic [31:0] h;
    h = a[31:0] * 32'h9E37_79B1;
    return h ^ a[63:32] ^ 32'h0000_1357;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // Fetch stream restarts at the (word-aligned) target; everything queued before is void.
  task automatic model_restart(input logic [63:0] pc);
    exp_q.delete();
    exp_next = {pc[63:2], 2'b00};
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 64'd4;
    end
  endtask

  // Memory: drives ready and returns accepted words in order after 1..N cycles.
  always @(posedge clk) begin
    #1;
    cyc_n++;
    imem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  end

  // Request-side checks and capture of accepted requests.
  always @(negedge clk) begin
    int d;
    if (rst) begin
      chk(!imem_req_valid, "req_valid_in_reset", 64'(imem_req_valid), 64'd0);
      req_exp  = RESET_PC;
      req_hold = 1'b0;
    end else if (redirect_valid) begin
      chk(!imem_req_valid, "req_during_redirect", 64'(imem_req_valid), 64'd0);
      req_exp  = {redirect_pc[63:2], 2'b00};
      req_hold = 1'b0;
    end else begin
      if (req_hold) begin
        chk(imem_req_valid && imem_req_addr == held_addr, "req_withdrawn", imem_req_addr,
            held_addr);
      end
      if (imem_req_valid) begin
        chk(imem_req_addr == req_exp, "req_addr", imem_req_addr, req_exp);
        if (imem_req_ready) begin
          d = cyc_n + $urandom_range(lat_min, lat_max);
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          pend.push_back('{addr: imem_req_addr, due: d});
          req_exp  = req_exp + 64'd4;
          req_hold = 1'b0;
        end else begin
          req_hold  = 1'b1;
          held_addr = imem_req_addr;
        end
      end else begin
        req_hold = 1'b0;
      end
    end
  end

  // Output monitor: pops the scoreboard on every word decode accepts.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      chk(!fetch_o_valid && fetch_o_pc == '0 && fetch_o_instr == '0, "outputs_in_reset",
          fetch_o_pc, 64'd0);
    end else if (!redirect_valid) begin
      if (!fetch_o_valid) begin
        chk(fetch_o_pc == '0 && fetch_o_instr == '0, "empty_outputs_zero", fetch_o_pc, 64'd0);
      end else begin
        top_up();
        if (regD_stall) begin
          chk(fetch_o_pc == exp_q[0], "stalled_head_pc", fetch_o_pc, exp_q[0]);
        end else begin
          e = exp_q.pop_front();
          chk(fetch_o_pc == e, "out_pc", fetch_o_pc, e);
          chk(fetch_o_instr == instr_of(e), "out_instr", 64'(fetch_o_instr), 64'(instr_of(e)));
          pop_cnt++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    model_restart(target);
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int t;
    int start;
    model_restart(RESET_PC);
    repeat (3) cyc();

    // Reset release with a 1-cycle memory: first word reaches decode in the third cycle.
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk(fetch_o_valid == (i == 3), "first_valid_cycle", 64'(fetch_o_valid), 64'(i == 3));
      if (i < 3) cyc();
    end
    chk(fetch_o_pc == RESET_PC, "first_pc", fetch_o_pc, RESET_PC);
    repeat (10) cyc();

    // Decode stall: FIFO fills and requests stop once all credit is used.
    regD_stall = 1'b1;
    repeat (10) cyc();
    @(negedge clk);
    chk(!imem_req_valid, "stall_req_stops", 64'(imem_req_valid), 64'd0);
    chk(fetch_o_valid, "stall_fifo_valid", 64'(fetch_o_valid), 64'd1);
    chk(pend.size() == 0, "stall_nothing_inflight", 64'(pend.size()), 64'd0);
    start = pop_cnt;
    cyc();
    regD_stall = 1'b0;
    repeat (4) cyc();
    chk(pop_cnt - start >= 4, "stall_drain", 64'(pop_cnt - start), 64'd4);
    repeat (6) cyc();

    // Redirect to an unaligned target with two words outstanding.
    lat_min = 3;
    lat_max = 3;
    t = 0;
    while (pend.size() != 2 && t < 100) begin
      cyc();
      t++;
    end
    chk(t < 100, "wait_two_inflight", 64'(t), 64'd100);
    do_redirect(64'h0000_0000_8000_1002);
    @(negedge clk);
    chk(imem_req_valid && imem_req_addr == 64'h0000_0000_8000_1000, "redirect_target_req",
        imem_req_addr, 64'h0000_0000_8000_1000);
    start = pop_cnt;
    repeat (20) cyc();
    chk(pop_cnt > start, "redirect_progress", 64'(pop_cnt - start), 64'd1);

    // Redirect in the same cycle as a returning word, with memory ready.
    lat_min = 2;
    lat_max = 2;
    t = 0;
    while (!imem_resp_valid && t < 100) begin
      cyc();
      t++;
    end
    chk(t < 100, "wait_resp", 64'(t), 64'd100);
    do_redirect(64'h0000_0000_8000_2000);
    start = pop_cnt;
    repeat (20) cyc();
    chk(pop_cnt > start, "redirect_resp_progress", 64'(pop_cnt - start), 64'd1);

    // Random ready, latency, stalls and occasional redirects over 1000 instructions.
    rand_ready = 1'b1;
    lat_min    = 1;
    lat_max    = 5;
    start      = pop_cnt;
    t          = 0;
    while (pop_cnt - start < 1000 && t < 20000) begin
      regD_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        do_redirect(RESET_PC + 64'($urandom & 32'h000F_FFFF));
      end else begin
        cyc();
      end
      t++;
    end
    chk(t < 20000, "random_1000_instrs", 64'(pop_cnt - start), 64'd1000);
    rand_ready = 1'b0;
    regD_stall = 1'b0;

    // Mid-operation reset with words outstanding; they return during reset and are ignored.
    lat_min = 5;
    lat_max = 5;
    t = 0;
    while (pend.size() < 3 && t < 100) begin
      cyc();
      t++;
    end
    chk(t < 100, "wait_three_inflight", 64'(t), 64'd100);
    rst = 1'b1;
    model_restart(RESET_PC);
    repeat (10) cyc();
    chk(pend.size() == 0, "reset_drained_mem", 64'(pend.size()), 64'd0);
    rst     = 1'b0;
    lat_min = 1;
    lat_max = 3;
    start   = pop_cnt;
    repeat (30) cyc();
    chk(pop_cnt > start, "restart_progress", 64'(pop_cnt - start), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
